// File: rtl/freq_divider_if.sv
// Divider control bundle: divide ratio in, divided clock out.
// Purely combinational wiring, no latency of its own.
// No backpressure: N is level-sampled and clk_out is free-running.
interface freq_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] N;
  logic             clk_out;

  modport master (output N, input  clk_out);
  modport slave  (input  N, output clk_out);
endinterface

// File: rtl/freq_divider.sv
// Programmable integer clock divider with 50% duty for even and odd ratios.
// Latency: clk_out rises on the first clk_in rise after reset (odd N: half a cycle later).
// No backpressure: the divisor is taken only at period starts, so a new N waits for the boundary.
module freq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk_in,
  input  logic          rst_n,
  freq_divider_if.slave div
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_l;
  logic             pos_q;
  logic             neg_q;
  logic             start_pend;

  logic             period_start;
  logic [WIDTH-1:0] n_sel;
  logic [WIDTH:0]   half_w;
  logic [WIDTH:0]   cnt_inc_w;
  logic             pos_nxt;

  // Period boundary detection and next-phase arithmetic; the extra bit keeps
  // (n_l+1) and (cnt+1) exact at the all-ones divisor.
  always_comb begin
    period_start = start_pend || (cnt == (n_l - ONE));
    n_sel        = (div.N == '0) ? ONE : div.N;
    half_w       = ({1'b0, n_l} + ONE_W) >> 1;
    cnt_inc_w    = {1'b0, cnt} + ONE_W;
    pos_nxt      = (cnt_inc_w < half_w);
  end

  // Rising-edge state: relatch divisor at period start, otherwise advance the count.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      n_l        <= ONE;
      pos_q      <= 1'b0;
      start_pend <= 1'b1;
    end else if (period_start) begin
      cnt        <= '0;
      n_l        <= n_sel;
      pos_q      <= 1'b1;
      start_pend <= 1'b0;
    end else begin
      cnt        <= cnt_inc_w[WIDTH-1:0];
      pos_q      <= pos_nxt;
    end
  end

  // Half-cycle delayed copy of the phase, used to centre odd-ratio pulses.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Output select: bypass for ratio 1, AND of both phases for odd ratios;
  // forced low while reset is held so the bypass path cannot leak clk_in.
  always_comb begin
    div.clk_out = 1'b0;
    if (rst_n) begin
      if (n_l == ONE) begin
        div.clk_out = clk_in;
      end else if (n_l[0]) begin
        div.clk_out = pos_q & neg_q;
      end else begin
        div.clk_out = pos_q;
      end
    end
  end

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: samples clk_out 2 time units after every
// clk_in edge (one sample per half cycle, oldest sample in the MSB) and
// compares against hand-written waveforms.
module tb_freq_divider;

  // A narrow divisor keeps the all-ones ratio short enough to simulate in full.
  localparam int WIDTH = 8;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  freq_divider_if #(.WIDTH(WIDTH)) div_if ();

  freq_divider #(.WIDTH(WIDTH)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .div    (div_if.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Sample nh half cycles starting at the next clk_in rise.
  task automatic capture(input int nh, output logic [63:0] v);
    v = '0;
    @(posedge clk_in);
    for (int i = 0; i < nh; i++) begin
      #2;
      v = {v[62:0], div_if.clk_out};
      if (i != nh - 1) @(clk_in);
    end
  endtask

  // Count high half cycles over nh half cycles starting at the next rise.
  task automatic count_high(input int nh, output int hi);
    hi = 0;
    @(posedge clk_in);
    for (int i = 0; i < nh; i++) begin
      #2;
      if (div_if.clk_out === 1'b1) hi++;
      if (i != nh - 1) @(clk_in);
    end
  endtask

  // Hold reset across one clk_in high phase with the new divisor applied,
  // then release in the low phase so the next rise is the first period start.
  task automatic do_reset(input logic [WIDTH-1:0] n);
    @(negedge clk_in);
    rst_n    = 1'b0;
    div_if.N = n;
    @(posedge clk_in);
    #1;
    chk("held_reset_high_clk", {63'd0, div_if.clk_out}, 64'd0);
    @(negedge clk_in);
    #1;
    rst_n = 1'b1;
  endtask

  logic [63:0] v;
  int          hi;

  initial begin
    div_if.N = 8'd2;
    #3;
    chk("reset_low_clk", {63'd0, div_if.clk_out}, 64'd0);
    @(posedge clk_in);
    #1;
    chk("reset_high_clk", {63'd0, div_if.clk_out}, 64'd0);

    // N=2: high one cycle, low one cycle, from the first rise
    do_reset(8'd2);
    capture(8, v);
    chk("n2", v, 64'b11001100);

    // N=3: rises at the falling edge, high 1.5 cycles
    do_reset(8'd3);
    capture(12, v);
    chk("n3", v, 64'b011100_011100);

    // N=4 with N=5 written mid-period: 4-cycle period completes first
    do_reset(8'd4);
    capture(4, v);
    chk("n4_first_half", v, 64'b1111);
    div_if.N = 8'd5;
    capture(24, v);
    chk("n4_to_n5", v, 64'b0000_0111110000_0111110000);

    // N=1 bypass, then N=0 behaves the same
    do_reset(8'd1);
    capture(8, v);
    chk("n1", v, 64'b10101010);
    do_reset(8'd0);
    capture(8, v);
    chk("n0", v, 64'b10101010);

    // 1 -> 2 at a period start: no runt pulse
    div_if.N = 8'd2;
    capture(8, v);
    chk("n1_to_n2", v, 64'b11001100);

    // 2 -> 1 written mid-period: the 2-period finishes, then bypass
    div_if.N = 8'd2;
    do_reset(8'd2);
    capture(6, v);
    chk("n2_before_switch", v, 64'b110011);
    div_if.N = 8'd1;
    capture(8, v);
    chk("n2_to_n1", v, 64'b00101010);

    // N=6, reset asserted in the middle of the high phase
    do_reset(8'd6);
    capture(4, v);
    chk("n6_high_phase", v, 64'b1111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("n6_async_drop", {63'd0, div_if.clk_out}, 64'd0);
    do_reset(8'd6);
    capture(24, v);
    chk("n6_after_reset", v, 64'b111111000000_111111000000);

    // All-ones divisor: 255 cycles per period, exactly 127.5 cycles high
    do_reset(8'd255);
    count_high(510, hi);
    chk("n255_high_p1", 64'(hi), 64'd255);
    count_high(510, hi);
    chk("n255_high_p2", 64'(hi), 64'd255);
    capture(4, v);
    chk("n255_next_start", v, 64'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
